// File: rtl/onehot_arbiter_rr.sv
// Packet-level round-robin arbiter: registered one-hot grant locked for a whole
// packet, priority rotating past the winner once its last beat transfers.
module onehot_arbiter_rr #(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           req_vld,
   input  logic [WIDTH-1:0]           req_lst,
   output logic [WIDTH-1:0]           req_rdy,
   output logic                       gnt_vld,
   output logic                       gnt_lst,
   input  logic                       gnt_rdy,
   output logic [WIDTH-1:0]           gnt_oht,
   output logic [$clog2(WIDTH)-1:0]   gnt_idx
);

   localparam int WIDTH_LOG = $clog2(WIDTH);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                 state_q, state_d;
   logic [WIDTH_LOG-1:0]   ptr_q, ptr_d;
   logic [WIDTH_LOG-1:0]   gnt_idx_q, gnt_idx_d;
   logic [WIDTH-1:0]       gnt_oht_q, gnt_oht_d;
   logic [WIDTH_LOG-1:0]   pick_idx, cand;
   logic                   pick_vld;
   logic                   xfer_lst;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= WIDTH_LOG'(WIDTH - 1);
         gnt_oht_q <= '0;
         gnt_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_oht_q <= gnt_oht_d;
         gnt_idx_q <= gnt_idx_d;
      end
   end

   // Rotating search ptr+1 .. ptr (mod WIDTH); only indices below WIDTH are visited.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int k = 1; k <= WIDTH; k++) begin
         cand = WIDTH_LOG'((int'(ptr_q) + k) % WIDTH);
         if (!pick_vld && req_vld[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_oht_d = gnt_oht_q;
      gnt_idx_d = gnt_idx_q;
      unique case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d   = BUSY;
               gnt_oht_d = {{(WIDTH-1){1'b0}}, 1'b1} << pick_idx;
               gnt_idx_d = pick_idx;
            end
         end
         BUSY: begin
            if (xfer_lst) begin
               state_d   = IDLE;
               ptr_d     = gnt_idx_q;
               gnt_oht_d = '0;
               gnt_idx_d = '0;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      req_rdy  = '0;
      gnt_vld  = 1'b0;
      gnt_lst  = 1'b0;
      xfer_lst = 1'b0;
      if (state_q == BUSY) begin
         gnt_vld  = req_vld[gnt_idx_q];
         gnt_lst  = req_vld[gnt_idx_q] & req_lst[gnt_idx_q];
         req_rdy  = gnt_rdy ? gnt_oht_q : '0;
         xfer_lst = req_vld[gnt_idx_q] & req_lst[gnt_idx_q] & gnt_rdy;
      end
   end

   assign gnt_oht = gnt_oht_q;
   assign gnt_idx = gnt_idx_q;

endmodule

// File: tb/tb_onehot_arbiter_rr.sv
// Bench for onehot_arbiter_rr: a WIDTH=4 and a WIDTH=5 instance driven by a
// packet-level requester model, with expected grant order held in a scoreboard.
module tb_onehot_arbiter_rr;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sel5 = 1'b0;
   logic [7:0] req_vld = '0;
   logic [7:0] req_lst = '0;
   logic       gnt_rdy = 1'b0;

   logic [3:0] rv4, rl4, req_rdy4, gnt_oht4;
   logic [1:0] gnt_idx4;
   logic       gnt_vld4, gnt_lst4;
   logic [4:0] rv5, rl5, req_rdy5, gnt_oht5;
   logic [2:0] gnt_idx5;
   logic       gnt_vld5, gnt_lst5;

   logic [7:0] m_rdy, m_oht;
   logic [2:0] m_idx;
   logic       m_vld, m_lst;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];
   int pkts[8];
   int len[8];
   int beats[8];
   logic [7:0] gap = '0;
   int sent_beats = 0;
   int dn_beats   = 0;
   int cur_idx    = 0;
   int idle_run   = 0;
   bit in_grant   = 1'b0;
   bit seen_end   = 1'b0;
   bit bubble_chk = 1'b0;

   always #5 clk = ~clk;

   assign rv4 = sel5 ? '0 : req_vld[3:0];
   assign rl4 = sel5 ? '0 : req_lst[3:0];
   assign rv5 = sel5 ? req_vld[4:0] : '0;
   assign rl5 = sel5 ? req_lst[4:0] : '0;

   assign m_rdy = sel5 ? {3'b0, req_rdy5} : {4'b0, req_rdy4};
   assign m_oht = sel5 ? {3'b0, gnt_oht5} : {4'b0, gnt_oht4};
   assign m_idx = sel5 ? gnt_idx5 : {1'b0, gnt_idx4};
   assign m_vld = sel5 ? gnt_vld5 : gnt_vld4;
   assign m_lst = sel5 ? gnt_lst5 : gnt_lst4;

   onehot_arbiter_rr #(.WIDTH(4)) u_dut4 (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_vld (rv4),
      .req_lst (rl4),
      .req_rdy (req_rdy4),
      .gnt_vld (gnt_vld4),
      .gnt_lst (gnt_lst4),
      .gnt_rdy (gnt_rdy),
      .gnt_oht (gnt_oht4),
      .gnt_idx (gnt_idx4)
   );

   onehot_arbiter_rr #(.WIDTH(5)) u_dut5 (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_vld (rv5),
      .req_lst (rl5),
      .req_rdy (req_rdy5),
      .gnt_vld (gnt_vld5),
      .gnt_lst (gnt_lst5),
      .gnt_rdy (gnt_rdy),
      .gnt_oht (gnt_oht5),
      .gnt_idx (gnt_idx5)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic set_pkt(input int i, input int n, input int l);
      pkts[i]  = n;
      len[i]   = l;
      beats[i] = l;
   endtask

   task automatic start_test(input bit bubble);
      for (int i = 0; i < 8; i++) set_pkt(i, 0, 1);
      gap        = '0;
      sent_beats = 0;
      dn_beats   = 0;
      seen_end   = 1'b0;
      bubble_chk = bubble;
   endtask

   task automatic drive();
      for (int i = 0; i < 8; i++) begin
         req_vld[i] = (pkts[i] > 0) && !gap[i];
         req_lst[i] = req_vld[i] && (beats[i] == 1);
      end
   endtask

   // Scoreboard side: each new grant pops the next expected winner; every busy
   // cycle re-checks the lock and the combinational handshake outputs.
   task automatic monitor();
      logic [7:0] exp_oht;
      logic       exp_vld;
      int         w;
      w = sel5 ? 5 : 4;
      if (m_oht != '0) begin
         if (!in_grant) begin
            in_grant = 1'b1;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL grant_order: got idx %0d, required no grant", m_idx);
               cur_idx = 0;
            end else begin
               cur_idx = exp_q.pop_front();
               if (m_idx !== 3'(cur_idx)) begin
                  n_fail++;
                  $display("FAIL grant_order: got idx %0d, required %0d", m_idx, cur_idx);
               end
            end
            if (bubble_chk && seen_end) begin
               n_checks++;
               if (idle_run != 1) begin
                  n_fail++;
                  $display("FAIL bubble: got %0d idle cycles, required 1", idle_run);
               end
            end
         end
         exp_oht = 8'd1 << cur_idx;
         n_checks++;
         if (m_oht !== exp_oht || m_idx !== 3'(cur_idx)) begin
            n_fail++;
            $display("FAIL grant_lock: got oht %b idx %0d, required oht %b idx %0d",
                     m_oht, m_idx, exp_oht, cur_idx);
         end
         n_checks++;
         if (int'(m_idx) >= w) begin
            n_fail++;
            $display("FAIL idx_range: got idx %0d, required below %0d", m_idx, w);
         end
         exp_vld = req_vld[cur_idx];
         n_checks++;
         if (m_vld !== exp_vld || m_lst !== (exp_vld & req_lst[cur_idx]) ||
             m_rdy !== (gnt_rdy ? exp_oht : 8'h00)) begin
            n_fail++;
            $display("FAIL busy_outputs: got vld %b lst %b rdy %b, required vld %b lst %b rdy %b",
                     m_vld, m_lst, m_rdy, exp_vld, exp_vld & req_lst[cur_idx],
                     gnt_rdy ? exp_oht : 8'h00);
         end
      end else begin
         if (in_grant) begin
            in_grant = 1'b0;
            seen_end = 1'b1;
            idle_run = 0;
         end
         idle_run++;
         n_checks++;
         if ({m_vld, m_lst, m_rdy, m_idx} !== '0) begin
            n_fail++;
            $display("FAIL idle_outputs: got vld %b lst %b rdy %b idx %0d, required all 0",
                     m_vld, m_lst, m_rdy, m_idx);
         end
      end
   endtask

   task automatic step();
      logic [7:0] fire;
      logic       dn;
      fire = req_vld & m_rdy;
      dn   = m_vld & gnt_rdy;
      @(posedge clk);
      #1;
      if (dn) dn_beats++;
      for (int i = 0; i < 8; i++) begin
         if (fire[i]) begin
            sent_beats++;
            beats[i]--;
            if (beats[i] == 0) begin
               pkts[i]--;
               beats[i] = len[i];
            end
         end
      end
      drive();
      #1;
      monitor();
   endtask

   function automatic bit pending();
      bit p;
      p = 1'b0;
      for (int i = 0; i < 8; i++) if (pkts[i] > 0) p = 1'b1;
      return p;
   endfunction

   task automatic run(input string name, input int budget);
      int cyc;
      cyc = 0;
      while ((exp_q.size() != 0 || pending() || in_grant) && cyc < budget) begin
         step();
         cyc++;
      end
      n_checks++;
      if (cyc >= budget || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_done: got %0d grants outstanding after %0d cycles, required 0",
                  name, exp_q.size(), cyc);
         exp_q.delete();
      end
   endtask

   task automatic step_until_sent(input string name, input int target);
      int cyc;
      cyc = 0;
      while (sent_beats < target && cyc < 20) begin
         step();
         cyc++;
      end
      n_checks++;
      if (sent_beats < target) begin
         n_fail++;
         $display("FAIL %s_wait: got %0d beats, required %0d", name, sent_beats, target);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start_test(1'b0);
      set_pkt(0, 1, 1);
      set_pkt(2, 1, 1);
      drive();
      @(posedge clk);
      #1;
      n_checks++;
      if ({gnt_oht4, gnt_idx4, gnt_vld4, gnt_lst4, req_rdy4} !== '0) begin
         n_fail++;
         $display("FAIL reset4: got oht %b idx %0d vld %b lst %b rdy %b, required all 0",
                  gnt_oht4, gnt_idx4, gnt_vld4, gnt_lst4, req_rdy4);
      end
      n_checks++;
      if ({gnt_oht5, gnt_idx5, gnt_vld5, gnt_lst5, req_rdy5} !== '0) begin
         n_fail++;
         $display("FAIL reset5: got oht %b idx %0d vld %b lst %b rdy %b, required all 0",
                  gnt_oht5, gnt_idx5, gnt_vld5, gnt_lst5, req_rdy5);
      end
   endtask

   task automatic test_first_grant();
      start_test(1'b1);
      gnt_rdy = 1'b1;
      set_pkt(1, 1, 1);
      set_pkt(3, 1, 1);
      drive();
      exp_q.push_back(1);
      exp_q.push_back(3);
      @(negedge clk);
      rst_n = 1'b1;
      run("first_grant", 20);
   endtask

   task automatic test_rotation();
      start_test(1'b1);
      set_pkt(0, 2, 1);
      set_pkt(1, 2, 1);
      set_pkt(2, 1, 1);
      set_pkt(3, 1, 1);
      drive();
      foreach (exp_q[k]) exp_q.delete(k);
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
      exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1);
      run("rotation", 40);
   endtask

   task automatic test_lock();
      start_test(1'b0);
      set_pkt(2, 1, 3);
      drive();
      exp_q.push_back(2);
      exp_q.push_back(0);
      step_until_sent("lock", 1);
      set_pkt(0, 1, 1);
      drive();
      #1;
      run("lock", 20);
      n_checks++;
      if (sent_beats != 4) begin
         n_fail++;
         $display("FAIL lock_beats: got %0d beats, required 4", sent_beats);
      end
   endtask

   task automatic test_backpressure();
      start_test(1'b0);
      set_pkt(1, 1, 4);
      drive();
      exp_q.push_back(1);
      step_until_sent("backpressure", 1);
      gnt_rdy = 1'b0;
      #1;
      step();
      step();
      n_checks++;
      if (dn_beats != 1 || sent_beats != 1) begin
         n_fail++;
         $display("FAIL stall_hold: got %0d/%0d beats, required 1/1", dn_beats, sent_beats);
      end
      gnt_rdy = 1'b1;
      gap[1]  = 1'b1;
      drive();
      #1;
      n_checks++;
      if (m_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL gap_vld: got gnt_vld %b, required 0", m_vld);
      end
      step();
      gap = '0;
      drive();
      #1;
      run("backpressure", 20);
      n_checks++;
      if (dn_beats != 4 || sent_beats != 4) begin
         n_fail++;
         $display("FAIL beat_count: got %0d delivered %0d sent, required 4 4", dn_beats, sent_beats);
      end
   endtask

   task automatic test_reset_mid();
      start_test(1'b0);
      set_pkt(3, 1, 4);
      drive();
      exp_q.push_back(3);
      step_until_sent("reset_mid", 1);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (gnt_oht4 !== 4'b0000 || gnt_vld4 !== 1'b0 || req_rdy4 !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_mid: got oht %b vld %b rdy %b, required 0000 0 0000",
                  gnt_oht4, gnt_vld4, req_rdy4);
      end
      start_test(1'b0);
      in_grant = 1'b0;
      exp_q.delete();
      set_pkt(0, 1, 1);
      set_pkt(3, 1, 1);
      drive();
      @(posedge clk);
      #1;
      n_checks++;
      if (gnt_oht4 !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_hold: got oht %b, required 0000", gnt_oht4);
      end
      exp_q.push_back(0);
      exp_q.push_back(3);
      @(negedge clk);
      rst_n = 1'b1;
      run("reset_mid", 20);
   endtask

   task automatic test_nonpow2();
      start_test(1'b1);
      sel5 = 1'b1;
      set_pkt(0, 2, 1);
      for (int i = 1; i < 5; i++) set_pkt(i, 1, 1);
      drive();
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
      exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(0);
      run("nonpow2", 40);
   endtask

   initial begin
      test_reset();
      test_first_grant();
      test_rotation();
      test_lock();
      test_backpressure();
      test_reset_mid();
      test_nonpow2();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
